lfm_out_reg: RTL and testbench

- Output register at the consumer end of the LFM phase-accumulator handshake.
- Advertises readiness, accepts SIGN_START_CALC/SIGN_STOP_CALC framing and latches NUM_OF_SAMPLES.
- Captures one ROM sample per clock (after the ROM read latency) and packs LANES samples into a DAC word.
- Buffers packed words in a FIFO and drains them to the DAC interface with valid/ready backpressure.

---
 rtl/lfm_out_reg_pkg.sv | 8 +
 rtl/lfm_out_reg_if.sv | 22 ++
 rtl/lfm_out_reg_sample_fifo.sv | 46 ++++
 rtl/lfm_out_reg.sv | 124 ++++++++++++
 tb/tb_lfm_out_reg.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/lfm_out_reg_pkg.sv
// lfm_out_pkg: shared types and sizing helpers for the LFM output register
package lfm_out_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, RUN, FLUSH, DRAIN} state_t;
  localparam int CNT_W = 32;
  function automatic int lane_idx_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction
endpackage

// File: rtl/lfm_out_reg_if.sv
// lfm_out_reg_if: accumulator framing, ROM sample and DAC handshake bundle
interface lfm_out_reg_if #(
  parameter int SAMPLE_W = 8,
  parameter int LANES = 4
);
  logic                        SIGN_START_CALC;
  logic                        SIGN_STOP_CALC;
  logic [31:0]                 NUM_OF_SAMPLES;
  logic [SAMPLE_W-1:0]         ROM_DATA;
  logic                        OUT_REG_READY;
  logic [LANES*SAMPLE_W-1:0]   DAC_DATA;
  logic                        DAC_VALID;
  logic                        DAC_READY;
  modport master (
    output SIGN_START_CALC, SIGN_STOP_CALC, NUM_OF_SAMPLES, ROM_DATA, DAC_READY,
    input  OUT_REG_READY, DAC_DATA, DAC_VALID
  );
  modport slave (
    input  SIGN_START_CALC, SIGN_STOP_CALC, NUM_OF_SAMPLES, ROM_DATA, DAC_READY,
    output OUT_REG_READY, DAC_DATA, DAC_VALID
  );
endinterface

// File: rtl/lfm_out_reg_sample_fifo.sv
// lfm_sample_fifo: word FIFO whose head is presented through a registered read stage
module lfm_sample_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         valid_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d, left;
  logic [W-1:0] dout_q;
  logic vld_q, wr_en, rd_en;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign rd_en = pop_i && cnt_q != '0;
  assign wr_en = push_i && (!full_o || rd_en);
  assign left = cnt_q - (AW+1)'(rd_en);
  assign cnt_d = left + (AW+1)'(wr_en);
  assign rd_d = rd_q + AW'(rd_en);
  assign dout_o = dout_q;
  assign valid_o = vld_q;
  always_ff @(posedge CLK)
    if (wr_en) mem_q[wr_q] <= din_i;
  // a word written into an otherwise empty FIFO bypasses straight to the head register
  always_ff @(posedge CLK)
    if (RESET) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      dout_q <= '0;
      vld_q <= 1'b0;
    end else begin
      wr_q <= wr_q + AW'(wr_en);
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      vld_q <= cnt_d != '0;
      dout_q <= (wr_en && left == '0) ? din_i : mem_q[rd_d];
    end
endmodule

// File: rtl/lfm_out_reg.sv
// lfm_out_reg: captures ROM samples of an LFM burst, packs them into DAC words and drains them
module lfm_out_reg
  import lfm_out_pkg::*;
#(
  parameter int SAMPLE_W = 8,
  parameter int LANES = 4,
  parameter int ROM_LATENCY = 1,
  parameter int FIFO_DEPTH = 16,
  parameter logic [SAMPLE_W-1:0] ZERO_CODE = 8'd128
) (
  input  logic              CLK,
  input  logic              RESET,
  lfm_out_reg_if.slave      bus,
  output logic              BUSY,
  output logic              DONE,
  output logic              LEN_ERR,
  output logic              OVF_ERR
);
  localparam int WORD_W = LANES * SAMPLE_W;
  localparam int LW = lane_idx_w(LANES);
  state_t state_q, state_d;
  logic [CNT_W-1:0] exp_cnt_q, exp_cnt_d, cap_cnt_q, cap_cnt_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [WORD_W-1:0] word_q, word_d, push_word;
  logic [ROM_LATENCY-1:0] vld_q, vld_d;
  logic rdy_q, rdy_d, len_q, len_d, ovf_q, ovf_d, done_q, done_d;
  logic push, full, fifo_vld, pop, cap;
  lfm_sample_fifo #(.W(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK(CLK),
    .RESET(RESET),
    .push_i(push),
    .din_i(push_word),
    .pop_i(pop),
    .dout_o(bus.DAC_DATA),
    .valid_o(fifo_vld),
    .full_o(full)
  );
  assign pop = fifo_vld && bus.DAC_READY;
  assign cap = vld_q[ROM_LATENCY-1];
  assign bus.DAC_VALID = fifo_vld;
  assign bus.OUT_REG_READY = rdy_q;
  assign BUSY = state_q != IDLE;
  assign DONE = done_q;
  assign LEN_ERR = len_q;
  assign OVF_ERR = ovf_q;
  always_comb begin
    state_d = state_q;
    exp_cnt_d = exp_cnt_q;
    cap_cnt_d = cap_cnt_q;
    lane_d = lane_q;
    word_d = word_q;
    push_word = word_q;
    rdy_d = rdy_q;
    len_d = len_q;
    done_d = 1'b0;
    push = 1'b0;
    vld_d = (vld_q << 1) | ROM_LATENCY'(state_q == RUN);
    if (cap) begin
      word_d[lane_q*SAMPLE_W +: SAMPLE_W] = bus.ROM_DATA;
      cap_cnt_d = cap_cnt_q + 1'b1;
      lane_d = lane_q + 1'b1;
      push = lane_q == LW'(LANES - 1);
      push_word = word_d;
    end
    case (state_q)
      IDLE:
        if (bus.SIGN_START_CALC) begin
          state_d = ARMED;
          len_d = 1'b0;
          cap_cnt_d = '0;
          lane_d = '0;
        end
      ARMED:
        if (!bus.SIGN_START_CALC) begin
          exp_cnt_d = bus.NUM_OF_SAMPLES;
          rdy_d = 1'b0;
          state_d = RUN;
        end
      RUN:
        if (bus.SIGN_STOP_CALC) state_d = FLUSH;
      FLUSH:
        if (vld_q == '0) begin
          for (int i = 0; i < LANES; i++)
            if (i >= int'(lane_q)) push_word[i*SAMPLE_W +: SAMPLE_W] = ZERO_CODE;
          push = lane_q != '0;
          lane_d = '0;
          len_d = len_q | (cap_cnt_q != exp_cnt_q);
          state_d = DRAIN;
        end
      DRAIN:
        if (!fifo_vld) begin
          state_d = IDLE;
          done_d = 1'b1;
          rdy_d = 1'b1;
        end
      default: state_d = IDLE;
    endcase
    ovf_d = (state_q == IDLE && bus.SIGN_START_CALC) ? 1'b0 : ovf_q | (push && full && !pop);
  end
  always_ff @(posedge CLK)
    if (RESET) begin
      state_q <= IDLE;
      exp_cnt_q <= '0;
      cap_cnt_q <= '0;
      lane_q <= '0;
      word_q <= '0;
      vld_q <= '0;
      rdy_q <= 1'b1;
      len_q <= 1'b0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_cnt_q <= exp_cnt_d;
      cap_cnt_q <= cap_cnt_d;
      lane_q <= lane_d;
      word_q <= word_d;
      vld_q <= vld_d;
      rdy_q <= rdy_d;
      len_q <= len_d;
      ovf_q <= ovf_d;
      done_q <= done_d;
    end
endmodule

// File: tb/tb_lfm_out_reg.sv
// tb_lfm_out_reg: drives identical bursts into ROM-latency 1 and 3 instances and scoreboards DAC words
module tb_lfm_out_reg;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic start = 1'b0, stop = 1'b0, rdy = 1'b1;
  logic [31:0] num = '0;
  logic [7:0] addr = '0;
  logic [7:0] pipe [3];
  logic busy1, done1, len1, ovf1, busy3, done3, len3, ovf3;
  logic v1_prev = 1'b0, v3_prev = 1'b0;
  logic [31:0] q1 [$];
  logic [31:0] q3 [$];
  int n_chk = 0, n_fail = 0;
  int cyc = 0, stop_cyc = 0, rise1 = 0, rise3 = 0, done1_cnt = 0, done3_cnt = 0;
  always #5 CLK = ~CLK;
  lfm_out_reg_if #(.SAMPLE_W(8), .LANES(4)) b1 ();
  lfm_out_reg_if #(.SAMPLE_W(8), .LANES(4)) b3 ();
  assign b1.SIGN_START_CALC = start;
  assign b1.SIGN_STOP_CALC = stop;
  assign b1.NUM_OF_SAMPLES = num;
  assign b1.DAC_READY = rdy;
  assign b1.ROM_DATA = pipe[0];
  assign b3.SIGN_START_CALC = start;
  assign b3.SIGN_STOP_CALC = stop;
  assign b3.NUM_OF_SAMPLES = num;
  assign b3.DAC_READY = rdy;
  assign b3.ROM_DATA = pipe[2];
  lfm_out_reg #(.ROM_LATENCY(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .bus(b1),
    .BUSY(busy1), .DONE(done1), .LEN_ERR(len1), .OVF_ERR(ovf1)
  );
  lfm_out_reg #(.ROM_LATENCY(3)) dut3 (
    .CLK(CLK), .RESET(RESET), .bus(b3),
    .BUSY(busy3), .DONE(done3), .LEN_ERR(len3), .OVF_ERR(ovf3)
  );
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    pipe[0] <= addr;
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge CLK)
    if (!RESET) begin
      if (b1.DAC_VALID && b1.DAC_READY) chk("dut1 word", b1.DAC_DATA, q1.size() != 0 ? q1.pop_front() : 32'bx);
      if (b3.DAC_VALID && b3.DAC_READY) chk("dut3 word", b3.DAC_DATA, q3.size() != 0 ? q3.pop_front() : 32'bx);
      if (b1.DAC_VALID && !v1_prev) rise1 = cyc;
      if (b3.DAC_VALID && !v3_prev) rise3 = cyc;
      v1_prev = b1.DAC_VALID;
      v3_prev = b3.DAC_VALID;
      done1_cnt += int'(done1);
      done3_cnt += int'(done3);
    end
  function automatic logic [31:0] word_of(input int k, input int n);
    logic [31:0] w;
    for (int l = 0; l < 4; l++) begin
      int s = 4 * k + l;
      w[l*8 +: 8] = (s < n) ? s[7:0] : 8'h80;
    end
    return w;
  endfunction
  task automatic burst(input int cnt, input int n, input bit hold);
    int t, nw, d1, d3;
    t = 0;
    while (!(b1.OUT_REG_READY && b3.OUT_REG_READY) && t < 100) begin
      @(posedge CLK);
      #1;
      t++;
    end
    chk("ready before start", t < 100, 1);
    nw = (n + 3) / 4;
    if (hold && nw > 16) nw = 16;
    for (int w = 0; w < nw; w++) begin
      q1.push_back(word_of(w, n));
      q3.push_back(word_of(w, n));
    end
    d1 = done1_cnt;
    d3 = done3_cnt;
    rdy = !hold;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    num = cnt;
    @(posedge CLK);
    #1;
    for (int k = 0; k < n; k++) begin
      addr = k[7:0];
      stop = k == n - 1;
      if (stop) stop_cyc = cyc;
      @(posedge CLK);
      #1;
    end
    stop = 1'b0;
    if (hold) begin
      repeat (6) @(posedge CLK);
      #1;
      rdy = 1'b1;
    end
    t = 0;
    while ((busy1 || busy3) && t < 400) begin
      @(posedge CLK);
      #1;
      t++;
    end
    @(negedge CLK);
    #1;
    chk("burst completes", t < 400, 1);
    chk("dut1 done pulses", done1_cnt - d1, 1);
    chk("dut3 done pulses", done3_cnt - d3, 1);
    chk("dut1 words left", q1.size(), 0);
    chk("dut3 words left", q3.size(), 0);
    chk("ready after burst", {b1.OUT_REG_READY, b3.OUT_REG_READY}, 2'b11);
  endtask
  initial begin
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    chk("dut1 reset flags", {b1.OUT_REG_READY, b1.DAC_VALID, busy1, done1, len1, ovf1}, 6'b100000);
    chk("dut3 reset flags", {b3.OUT_REG_READY, b3.DAC_VALID, busy3, done3, len3, ovf3}, 6'b100000);
    chk("dut1 reset data", b1.DAC_DATA, 0);
    chk("dut3 reset data", b3.DAC_DATA, 0);
    burst(8, 8, 1'b0);
    chk("nominal len/ovf", {len1, len3, ovf1, ovf3}, 4'b0000);
    burst(6, 6, 1'b0);
    chk("partial len", {len1, len3}, 2'b00);
    burst(4, 4, 1'b0);
    chk("dut1 stop to valid", rise1 - stop_cyc, 2);
    chk("dut3 stop to valid", rise3 - stop_cyc, 4);
    burst(10, 8, 1'b0);
    chk("mismatch len", {len1, len3}, 2'b11);
    repeat (5) @(negedge CLK);
    chk("len sticky in idle", {len1, len3}, 2'b11);
    burst(0, 1, 1'b0);
    chk("zero count len", {len1, len3}, 2'b11);
    burst(8, 8, 1'b0);
    chk("len cleared by start", {len1, len3}, 2'b00);
    burst(128, 128, 1'b1);
    chk("backpressure ovf", {ovf1, ovf3}, 2'b11);
    chk("backpressure len", {len1, len3}, 2'b00);
    burst(4, 4, 1'b0);
    chk("ovf cleared by start", {ovf1, ovf3}, 2'b00);
    rdy = 1'b0;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    num = 8;
    @(posedge CLK);
    #1;
    for (int k = 0; k < 5; k++) begin
      addr = k[7:0];
      @(posedge CLK);
      #1;
    end
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    chk("dut1 after mid reset", {b1.OUT_REG_READY, b1.DAC_VALID, busy1}, 3'b100);
    chk("dut3 after mid reset", {b3.OUT_REG_READY, b3.DAC_VALID, busy3}, 3'b100);
    #1;
    rdy = 1'b1;
    repeat (10) @(negedge CLK);
    chk("fifo empty after reset", {b1.DAC_VALID, b3.DAC_VALID, busy1, busy3}, 4'b0000);
    burst(8, 8, 1'b0);
    chk("recovery len/ovf", {len1, len3, ovf1, ovf3}, 4'b0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
